// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the muxed-bus arbiter.
package mux_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // First requester at or after ptr, wrapping over n slots; returns ptr when none request.
    function automatic int rr_pick(input logic [31:0] req, input int ptr, input int n);
        int  idx;
        bit  found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (!found && req[idx[4:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// Plain N:1 data selector; the arbiter drives its select.
module Mux #(
    parameter int SELECT_BITS = 2,
    parameter int WIDTH       = 16
) (
    input  logic [2**SELECT_BITS-1:0][WIDTH-1:0] in,
    input  logic [SELECT_BITS-1:0]               select,
    output logic [WIDTH-1:0]                     out
);

    assign out = in[select];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter: grants one requester a burst on the shared datapath, then rotates.
module rr_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int SELECT_BITS = 2,
    parameter int WIDTH       = 16,
    parameter int MAX_BEATS   = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [2**SELECT_BITS-1:0]            req,
    input  logic [2**SELECT_BITS-1:0]            last,
    input  logic [2**SELECT_BITS-1:0][WIDTH-1:0] in,
    input  logic                                 out_ready,
    output logic                                 out_valid,
    output logic [WIDTH-1:0]                     out,
    output logic [2**SELECT_BITS-1:0]            ack,
    output logic [SELECT_BITS-1:0]               grant_sel,
    output logic                                 busy
);

    localparam int N      = 2**SELECT_BITS;
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);

    arb_state_t             state_reg;
    logic [SELECT_BITS-1:0] ptr_reg;
    logic [SELECT_BITS-1:0] grant_sel_reg;
    logic [BEAT_W-1:0]      beats_reg;
    logic [BEAT_W-1:0]      beats_next;
    logic [SELECT_BITS-1:0] winner;
    logic                   transfer;
    logic                   owner_req;
    logic                   release_burst;

    assign winner    = SELECT_BITS'(rr_pick(32'(req), int'(ptr_reg), N));
    assign owner_req = req[grant_sel_reg];

    // Gated by reset so a reset landing mid-burst never completes a beat.
    assign out_valid = (state_reg == GRANT) && owner_req && !reset;
    assign transfer  = out_valid && out_ready;

    assign beats_next    = beats_reg + 1'b1;
    assign release_burst = last[grant_sel_reg] || (beats_next == BEAT_W'(MAX_BEATS));

    assign busy      = (state_reg == GRANT);
    assign grant_sel = grant_sel_reg;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ack
            assign ack[gi] = transfer && (grant_sel_reg == SELECT_BITS'(gi));
        end
    endgenerate

    Mux #(
        .SELECT_BITS (SELECT_BITS),
        .WIDTH       (WIDTH)
    ) u_mux (
        .in     (in),
        .select (grant_sel_reg),
        .out    (out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            grant_sel_reg <= '0;
            beats_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        grant_sel_reg <= winner;
                        beats_reg     <= '0;
                        state_reg     <= GRANT;
                    end
                end
                GRANT: begin
                    // A withdrawn owner gives up the bus just like a finished burst.
                    if (!owner_req) begin
                        state_reg <= IDLE;
                        ptr_reg   <= grant_sel_reg + 1'b1;
                        beats_reg <= '0;
                    end else if (transfer) begin
                        if (release_burst) begin
                            state_reg <= IDLE;
                            ptr_reg   <= grant_sel_reg + 1'b1;
                            beats_reg <= '0;
                        end else begin
                            beats_reg <= beats_next;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with a scoreboard of expected transfers.
module tb_rr_mux_arbiter;

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req;
    logic [3:0]       last;
    logic [3:0][15:0] in_bus;
    logic             out_ready;
    logic             out_valid;
    logic [15:0]      out_data;
    logic [3:0]       ack;
    logic [1:0]       grant_sel;
    logic             busy;

    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];

    rr_mux_arbiter #(
        .SELECT_BITS (2),
        .WIDTH       (16),
        .MAX_BEATS   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .in        (in_bus),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out       (out_data),
        .ack       (ack),
        .grant_sel (grant_sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h @%0t", name, act, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] idx, input int count);
        exp_t e;
        e.idx  = idx;
        e.data = in_bus[idx];
        for (int k = 0; k < count; k++) exp_q.push_back(e);
    endtask

    // Monitor: every accepted beat must match the oldest expected transfer.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_xfer: got grant_sel=%0d out=%0h ack=%b expected=no transfer @%0t",
                             grant_sel, out_data, ack, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("xfer_sel", 32'(grant_sel), 32'(e.idx));
                    check("xfer_data", 32'(out_data), 32'(e.data));
                    check("xfer_ack", 32'(ack), 32'(4'b0001 << e.idx));
                end
            end else begin
                check("ack_idle", 32'(ack), 32'd0);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req       = '0;
        last      = '0;
        out_ready = 1'b0;
        in_bus[0] = 16'h1111;
        in_bus[1] = 16'h2222;
        in_bus[2] = 16'h3333;
        in_bus[3] = 16'h4444;
        next();
        next();
        mon_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_sel", 32'(grant_sel), 32'd0);
        check("rst_out", 32'(out_data), 32'h1111);
        next();
        reset = 1'b0;

        // 1: single request
        req = 4'b0100; last = 4'b0100; out_ready = 1'b1; in_bus[2] = 16'hBEEF;
        push(2'd2, 1);
        @(negedge clk);
        check("t1_idle_valid", 32'(out_valid), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        next();
        @(negedge clk);
        check("t1_grant_busy", 32'(busy), 32'd1);
        check("t1_grant_sel", 32'(grant_sel), 32'd2);
        next();
        req = 4'b0000;
        @(negedge clk);
        check("t1_release_busy", 32'(busy), 32'd0);
        next();
        in_bus[2] = 16'h3333;

        // 2: rotation 0,1,2,3,0 from a fresh pointer
        reset = 1'b1;
        next();
        reset = 1'b0;
        req = 4'b1111; last = 4'b1111;
        push(2'd0, 1); push(2'd1, 1); push(2'd2, 1); push(2'd3, 1); push(2'd0, 1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check("t2_valid", 32'(out_valid), 32'((c % 2) == 0));
            next();
        end
        req = 4'b0000;
        next();

        // 3: burst cap, then re-grant to the only requester (ptr wraps back to 1)
        req = 4'b0010; last = 4'b0000;
        push(2'd1, 5);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check("t3_valid", 32'(out_valid), 32'(c != 1 && c != 6));
            next();
        end
        req = 4'b0000;
        next();

        // 4: backpressure holds the beat and the beat count
        reset = 1'b1;
        next();
        reset = 1'b0;
        req = 4'b0001; last = 4'b0000; out_ready = 1'b0;
        push(2'd0, 4);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check("t4_valid", 32'(out_valid), 32'(c >= 2 && c <= 8));
            if (c >= 2 && c <= 4) begin
                check("t4_stall_ack", 32'(ack), 32'd0);
                check("t4_stall_out", 32'(out_data), 32'h1111);
            end
            next();
            if (c == 4) out_ready = 1'b1;
            if (c == 8) req = 4'b0000;
        end

        // 5: owner withdrawal hands off to 0; late req[1] waits for arbitration
        req = 4'b1000; last = 4'b0011;
        push(2'd3, 1); push(2'd0, 1); push(2'd1, 1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check("t5_valid", 32'(out_valid), 32'(c == 2 || c == 5 || c == 7));
            if (c == 3) check("t5_withdraw_busy", 32'(busy), 32'd1);
            if (c == 4) check("t5_bubble_busy", 32'(busy), 32'd0);
            next();
            if (c == 1) req = 4'b1010;
            if (c == 2) req = 4'b0011;
        end
        req = 4'b0000;
        next();

        // 6: reset during the second beat of a burst
        req = 4'b0100; last = 4'b0000;
        push(2'd2, 1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 3) begin
                check("t6_rst_valid", 32'(out_valid), 32'd0);
                check("t6_rst_ack", 32'(ack), 32'd0);
            end
            if (c == 4) begin
                check("t6_post_busy", 32'(busy), 32'd0);
                check("t6_post_valid", 32'(out_valid), 32'd0);
                check("t6_post_sel", 32'(grant_sel), 32'd0);
            end
            if (c == 5) check("t6_first_sel", 32'(grant_sel), 32'd1);
            if (c == 7) check("t6_second_sel", 32'(grant_sel), 32'd3);
            next();
            if (c == 2) reset = 1'b1;
            if (c == 3) begin
                reset = 1'b0;
                req   = 4'b1010;
                last  = 4'b1010;
                push(2'd1, 1);
                push(2'd3, 1);
            end
        end
        req = 4'b0000;
        next();
        next();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
